// File: rtl/reduce_pkg.sv
// Shared opcode constants and FSM state encoding for the reduce_arbiter slice.
package reduce_pkg;

  localparam logic [2:0] OP_AND_OR  = 3'd0;
  localparam logic [2:0] OP_OR_AND  = 3'd1;
  localparam logic [2:0] OP_XOR_ADD = 3'd2;
  localparam logic [2:0] OP_AND_SHL = 3'd3;
  localparam logic [2:0] OP_OR_NEST = 3'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/reduce_unit.sv
// Combinational grouped-reduction evaluator: one of five expressions over 8-bit operands.
module reduce_unit
  import reduce_pkg::*;
(
  input  logic [2:0] op,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [7:0] c,
  output logic       rbit,
  output logic       err
);

  // Sum and shift are held at 8 bits so carry and shifted-out bits are dropped.
  logic [7:0] sum;
  logic [7:0] shl;

  assign sum = a + b;
  assign shl = a << 2;

  always_comb begin
    rbit = 1'b0;
    err  = 1'b0;
    case (op)
      OP_AND_OR:  rbit = &(a | b);
      OP_OR_AND:  rbit = |(a & b);
      OP_XOR_ADD: rbit = ^sum;
      OP_AND_SHL: rbit = &(shl | b);
      OP_OR_NEST: rbit = |(a & (b | c));
      default:    err  = 1'b1;
    endcase
  end

endmodule

// File: rtl/reduce_arbiter.sv
// Round-robin arbiter sharing one reduce_unit among N_REQ requesters, with a
// registered valid/ready response carrying the owner index.
module reduce_arbiter
  import reduce_pkg::*;
#(
  parameter int unsigned N_REQ = 3,
  parameter int unsigned ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [3*N_REQ-1:0]   req_op,
  input  logic [8*N_REQ-1:0]   req_a,
  input  logic [8*N_REQ-1:0]   req_b,
  input  logic [8*N_REQ-1:0]   req_c,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic                 rsp_bit,
  output logic                 rsp_err
);

  state_e state_q, state_d;

  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [ID_W-1:0]    win;
  logic [ID_W-1:0]    off;
  logic [ID_W:0]      win_sum;
  logic [ID_W:0]      nxt_sum;
  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0]   rot;
  logic               found;
  logic               grant_window;
  logic               grant;

  logic [2:0]         sel_op;
  logic [7:0]         sel_a, sel_b, sel_c;

  logic [2:0]         op_q;
  logic [7:0]         a_q, b_q, c_q;
  logic [ID_W-1:0]    id_q;

  logic               rsp_valid_q;
  logic [ID_W-1:0]    rsp_id_q;
  logic               rsp_bit_q;
  logic               rsp_err_q;

  logic               unit_bit;
  logic               unit_err;

  // Rotate the request vector so bit 0 is the current priority holder, then
  // take the first set bit and map its offset back to an absolute index.
  always_comb begin
    dbl   = {req_valid, req_valid} >> ptr_q;
    rot   = dbl[N_REQ-1:0];
    found = 1'b0;
    off   = '0;
    for (int k = 0; k < int'(N_REQ); k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        off   = ID_W'(k);
      end
    end
    win_sum = {1'b0, ptr_q} + {1'b0, off};
    if (win_sum >= (ID_W+1)'(N_REQ)) begin
      win = ID_W'(win_sum - (ID_W+1)'(N_REQ));
    end else begin
      win = win_sum[ID_W-1:0];
    end
  end

  assign grant_window = (state_q == IDLE) || ((state_q == DONE) && rsp_ready);
  assign grant        = !rst && grant_window && found;

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      req_ready[i] = grant && (win == ID_W'(i));
    end
  end

  always_comb begin
    sel_op = '0;
    sel_a  = '0;
    sel_b  = '0;
    sel_c  = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (win == ID_W'(i)) begin
        sel_op = req_op[3*i +: 3];
        sel_a  = req_a[8*i +: 8];
        sel_b  = req_b[8*i +: 8];
        sel_c  = req_c[8*i +: 8];
      end
    end
  end

  always_comb begin
    nxt_sum = {1'b0, win} + (ID_W+1)'(1);
    ptr_d   = ptr_q;
    if (grant) begin
      ptr_d = (nxt_sum == (ID_W+1)'(N_REQ)) ? '0 : nxt_sum[ID_W-1:0];
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (grant) state_d = EXEC;
      EXEC: state_d = DONE;
      DONE: if (rsp_ready) state_d = grant ? EXEC : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      id_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_bit_q   <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      if (grant) begin
        op_q <= sel_op;
        a_q  <= sel_a;
        b_q  <= sel_b;
        c_q  <= sel_c;
        id_q <= win;
      end
      if (state_q == EXEC) begin
        rsp_valid_q <= 1'b1;
        rsp_id_q    <= id_q;
        rsp_bit_q   <= unit_bit;
        rsp_err_q   <= unit_err;
      end else if ((state_q == DONE) && rsp_ready) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

  reduce_unit u_reduce_unit (
    .op   (op_q),
    .a    (a_q),
    .b    (b_q),
    .c    (c_q),
    .rbit (unit_bit),
    .err  (unit_err)
  );

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_bit   = rsp_bit_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_reduce_arbiter.sv
// Directed self-checking bench for reduce_arbiter with N_REQ=3.
module tb_reduce_arbiter;

  localparam int unsigned N  = 3;
  localparam int unsigned IW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [3*N-1:0]  req_op;
  logic [8*N-1:0]  req_a, req_b, req_c;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [IW-1:0]   rsp_id;
  logic            rsp_bit;
  logic            rsp_err;

  int errors = 0;
  int checks = 0;

  logic [2:0] exp_rdy [9] = '{3'b001, 3'b000, 3'b010, 3'b000, 3'b100,
                              3'b000, 3'b001, 3'b000, 3'b010};
  logic       exp_vld [9] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [1:0] exp_id  [9] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd2, 2'd0, 2'd0};

  always #5 clk = ~clk;

  reduce_arbiter #(
    .N_REQ (N),
    .ID_W  (IW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_c     (req_c),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_bit   (rsp_bit),
    .rsp_err   (rsp_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #2;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic set_req(input int i, input logic [2:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic [7:0] c);
    req_op[3*i +: 3] = op;
    req_a[8*i +: 8]  = a;
    req_b[8*i +: 8]  = b;
    req_c[8*i +: 8]  = c;
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] c,
                        input logic eb, input logic ee);
    set_req(0, op, a, b, c);
    req_valid = 3'b001;
    settle;
    chk({tag, "_rdy"}, req_ready, 3'b001);
    step;
    req_valid = 3'b000;
    step;
    chk({tag, "_vld"}, rsp_valid, 1'b1);
    chk({tag, "_id"}, rsp_id, 2'd0);
    chk({tag, "_bit"}, rsp_bit, eb);
    chk({tag, "_err"}, rsp_err, ee);
    step;
    chk({tag, "_vld_clr"}, rsp_valid, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    req_valid = 3'b111;
    rsp_ready = 1'b1;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    req_c     = '0;
    step;
    step;
    chk("rst_rdy", req_ready, 3'b000);
    chk("rst_vld", rsp_valid, 1'b0);
    chk("rst_id", rsp_id, 2'd0);
    chk("rst_bit", rsp_bit, 1'b0);
    chk("rst_err", rsp_err, 1'b0);

    // Fairness: all three requesting from reset, consumer always ready.
    rst = 1'b0;
    settle;
    for (int cyc = 0; cyc < 9; cyc++) begin
      chk($sformatf("fair_rdy%0d", cyc), req_ready, exp_rdy[cyc]);
      chk($sformatf("fair_vld%0d", cyc), rsp_valid, exp_vld[cyc]);
      if (exp_vld[cyc]) chk($sformatf("fair_id%0d", cyc), rsp_id, exp_id[cyc]);
      if (cyc == 8) req_valid = 3'b000;
      step;
    end

    // Opcode vectors on requester 0.
    run_op("op0",    3'd0, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b0);
    run_op("op1",    3'd1, 8'h0F, 8'hF0, 8'h00, 1'b0, 1'b0);
    run_op("op2w",   3'd2, 8'hFF, 8'h01, 8'h00, 1'b0, 1'b0);
    run_op("op2",    3'd2, 8'h01, 8'h01, 8'h00, 1'b1, 1'b0);
    run_op("op3",    3'd3, 8'h3F, 8'h03, 8'h00, 1'b1, 1'b0);
    run_op("op4",    3'd4, 8'h80, 8'h00, 8'h80, 1'b1, 1'b0);
    run_op("op6",    3'd6, 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b1);

    // Backpressure: requester 1 result held while requester 2 waits.
    rsp_ready = 1'b0;
    set_req(1, 3'd1, 8'hFF, 8'h01, 8'h00);
    set_req(2, 3'd0, 8'hFF, 8'h00, 8'h00);
    req_valid = 3'b010;
    settle;
    chk("bp_rdy_idle", req_ready, 3'b010);
    step;
    req_valid = 3'b100;
    settle;
    chk("bp_exec_rdy", req_ready, 3'b000);
    chk("bp_exec_vld", rsp_valid, 1'b0);
    step;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp_vld%0d", i), rsp_valid, 1'b1);
      chk($sformatf("bp_id%0d", i), rsp_id, 2'd1);
      chk($sformatf("bp_bit%0d", i), rsp_bit, 1'b1);
      chk($sformatf("bp_rdy%0d", i), req_ready, 3'b000);
      step;
    end
    rsp_ready = 1'b1;
    settle;
    chk("bp_release_rdy", req_ready, 3'b100);
    step;
    req_valid = 3'b000;
    chk("bp_exec2_vld", rsp_valid, 1'b0);
    step;
    chk("bp_r2_vld", rsp_valid, 1'b1);
    chk("bp_r2_id", rsp_id, 2'd2);
    chk("bp_r2_bit", rsp_bit, 1'b1);
    step;

    // Operand isolation: req_a changes after the accept edge.
    set_req(0, 3'd0, 8'hFF, 8'h00, 8'h00);
    req_valid = 3'b001;
    step;
    req_valid = 3'b000;
    set_req(0, 3'd0, 8'h00, 8'h00, 8'h00);
    step;
    chk("iso_vld", rsp_valid, 1'b1);
    chk("iso_bit", rsp_bit, 1'b1);
    step;

    // Reset during EXEC discards the in-flight request.
    set_req(1, 3'd1, 8'hFF, 8'hFF, 8'h00);
    req_valid = 3'b010;
    step;
    rst       = 1'b1;
    req_valid = 3'b011;
    step;
    chk("rx_rdy", req_ready, 3'b000);
    chk("rx_vld", rsp_valid, 1'b0);
    chk("rx_id", rsp_id, 2'd0);
    chk("rx_bit", rsp_bit, 1'b0);
    chk("rx_err", rsp_err, 1'b0);
    rst       = 1'b0;
    req_valid = 3'b000;
    for (int i = 0; i < 3; i++) begin
      step;
      chk($sformatf("rx_quiet%0d", i), rsp_valid, 1'b0);
    end
    req_valid = 3'b011;
    settle;
    chk("rx_next_rdy", req_ready, 3'b001);
    step;
    req_valid = 3'b000;
    step;
    chk("rx_next_id", rsp_id, 2'd0);
    step;

    // Pointer wrap: requester 2 alone, then 0 and 1 together.
    set_req(2, 3'd0, 8'h00, 8'h00, 8'h00);
    req_valid = 3'b100;
    settle;
    chk("wrap_rdy2", req_ready, 3'b100);
    step;
    req_valid = 3'b011;
    step;
    chk("wrap_id2", rsp_id, 2'd2);
    chk("wrap_rdy0", req_ready, 3'b001);
    step;
    req_valid = 3'b000;
    step;
    chk("wrap_vld0", rsp_valid, 1'b1);
    chk("wrap_id0", rsp_id, 2'd0);
    step;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
